mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter and access sequencer for the 5-stage pipeline. Shares one multi-cycle SRAM port between the instruction-fetch stage and the MEM stage (load/store). Serialises accesses, holds SRAM controls stable for a fixed wait period, and returns one-cycle completion pulses from which the pipeline derives its freeze signals.

## Interface
Parameters:
- DATA_W, 32, data and address width
- SRAM_WAIT, 2, extra SRAM wait cycles per access (legal 0..15)
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (fairness build only; legal 1..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch wants the instruction at if_addr
- if_addr  in  DATA_W  fetch byte address, low 2 bits ignored
- if_flush  in  1  branch taken; in-flight fetch result is discarded
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle pulse, if_rdata valid
- mem_rd  in  1  load request
- mem_wr  in  1  store request
- mem_addr  in  DATA_W  data byte address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data
- mem_ready  out  1  one-cycle pulse, load/store complete
- freez_if  out  1  if_req & ~if_valid
- freez_mem  out  1  (mem_rd | mem_wr) & ~mem_ready
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  DATA_W  word-aligned SRAM address {addr[31:2],2'b0}
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid while sram_en high after SRAM_WAIT cycles

## Operation
- States: IDLE, FETCH, DATA, RESP.
- IDLE: if mem_rd|mem_wr → DATA; else if if_req → FETCH; else stay. Data wins ties (older instruction). Grant latches address, wdata, write flag (mem_wr wins if both rd and wr high), loads wait counter with SRAM_WAIT.
- FETCH/DATA: sram_en=1, sram_addr/sram_wdata from latched regs, sram_we=1 only in DATA with write flag. Counter decrements each cycle; in the cycle counter==0, sram_rdata captured into if_rdata or mem_rdata (reads only), state → RESP.
- RESP: exactly one of if_valid/mem_ready high for this cycle; sram_en=0; requests ignored; next state IDLE.
- Store: mem_rdata unchanged; mem_ready still pulses.
- if_flush high during grant cycle or any FETCH cycle sets drop flag: access completes on SRAM, if_rdata not updated, if_valid suppressed in RESP. if_flush in RESP or IDLE has no effect. Drop flag cleared on entering IDLE.
- if_rdata/mem_rdata hold last value until next capture.
- Requester inputs may change freely except while their own freeze is high; arbiter uses only latched values after grant.

## Timing
- Request seen in IDLE at cycle T → SRAM active T+1..T+1+SRAM_WAIT → pulse at T+SRAM_WAIT+2 → IDLE at T+SRAM_WAIT+3. Default: pulse at T+4, 5 cycles per access.
- Back-to-back: one IDLE cycle between accesses; no request is granted twice.
- Reset (any state, mid-access included): state IDLE, counter 0, drop flag 0, fairness count 0; sram_en, sram_we, if_valid, mem_ready = 0; sram_addr, sram_wdata, if_rdata, mem_rdata = 0. Aborted SRAM write not re-issued.
- freez_if/freez_mem combinational from inputs and registered pulses; all other outputs registered or decoded from state.

## Configuration
- ARB_FAIRNESS_EN defined: counter increments on each DATA grant while if_req high, clears on each FETCH grant; when it equals STARVE_MAX, next IDLE grant goes to fetch if if_req high, even with data pending.
- Not defined: strict data priority, no counter, STARVE_MAX unused.

## Structure
- Package arb_pkg: state encodings (IDLE=0, FETCH=1, DATA=2, RESP=3), default SRAM_WAIT and STARVE_MAX constants.
- Sub-module arb_wait_cnt: 4-bit load/decrement counter with zero flag; arbiter FSM and data latches in mem_arbiter.

## Test plan
- Fetch only, SRAM_WAIT=2, if_addr=0x10, SRAM word 0x8001060A → sram_en high 3 cycles, if_valid at T+4 with if_rdata=0x8001060A, freez_if low in that cycle.
- Simultaneous if_req and mem_wr (addr 0x400, wdata 0x1234) → DATA first, sram_we high 3 cycles, mem_ready at T+4; fetch granted at T+5, if_valid at T+9.
- if_flush pulse in second FETCH cycle → SRAM access completes, no if_valid, if_rdata unchanged, next fetch granted normally.
- rst asserted mid-DATA write → next cycle all outputs zero, state IDLE, no mem_ready; write not repeated after reset release.
- mem_rd and if_req held high continuously, ARB_FAIRNESS_EN, STARVE_MAX=4 → grant sequence D,D,D,D,F,D,...; without macro → fetch never granted.
- mem_rd and mem_wr both high → treated as write, mem_rdata unchanged, mem_ready single pulse.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter.
// Optional build macro used by mem_arbiter: ARB_FAIRNESS_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int ARB_SRAM_WAIT_DEF  = 2;
  localparam int ARB_STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_wait_cnt.sv
// 4-bit load/decrement wait counter with zero flag; saturates at zero.
module arb_wait_cnt
  import arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle SRAM port between instruction fetch and load/store.
// Build macro ARB_FAIRNESS_EN: bounds fetch starvation to STARVE_MAX data grants.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SRAM_WAIT  = ARB_SRAM_WAIT_DEF,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freez_if,
  output logic              freez_mem,
  output logic              sram_en,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [3:0] WAIT_LD = 4'(SRAM_WAIT);

  // Out-of-range parameters leave an obvious marker in the elaborated hierarchy.
  if (SRAM_WAIT < 0 || SRAM_WAIT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_illegal_params
  end

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              we_q, we_d, fetch_q, fetch_d, drop_q, drop_d;
  logic              data_req_s, grant_fetch_s, grant_data_s, fetch_first_s, wait_zero_s;

  assign data_req_s    = mem_rd | mem_wr;
  assign grant_fetch_s = (state_q == ST_IDLE) && if_req && (!data_req_s || fetch_first_s);
  assign grant_data_s  = (state_q == ST_IDLE) && data_req_s && !grant_fetch_s;

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;

  assign fetch_first_s = if_req && (starve_q == STARVE_LIM);

  // Counts data grants that overtook a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (grant_fetch_s) begin
      starve_d = 4'd0;
    end else if (grant_data_s && if_req) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_first_s = 1'b0;
`endif

  arb_wait_cnt u_wait_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (grant_fetch_s | grant_data_s),
    .dec_i      (sram_en),
    .load_val_i (WAIT_LD),
    .zero_o     (wait_zero_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_data_s) begin
          state_d = ST_DATA;
        end else if (grant_fetch_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (wait_zero_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_en   = (state_q == ST_FETCH) || (state_q == ST_DATA);
    sram_we   = (state_q == ST_DATA) && we_q;
    if_valid  = (state_q == ST_RESP) && fetch_q && !drop_q;
    mem_ready = (state_q == ST_RESP) && !fetch_q;
  end

  // Grant-time latches, flush tracking and read-data capture.
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    fetch_d     = fetch_q;
    drop_d      = drop_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if (grant_data_s) begin
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      we_d    = mem_wr;
      fetch_d = 1'b0;
    end else if (grant_fetch_s) begin
      addr_d  = if_addr;
      we_d    = 1'b0;
      fetch_d = 1'b1;
    end else begin
      addr_d = addr_q;
    end
    if (state_q == ST_RESP) begin
      drop_d = 1'b0;
    end else if ((grant_fetch_s || (state_q == ST_FETCH)) && if_flush) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
    if ((state_q == ST_FETCH) && wait_zero_s && !drop_q && !if_flush) begin
      if_rdata_d = sram_rdata;
    end else if ((state_q == ST_DATA) && wait_zero_s && !we_q) begin
      mem_rdata_d = sram_rdata;
    end else begin
      if_rdata_d = if_rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      fetch_q     <= 1'b0;
      drop_q      <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      fetch_q     <= fetch_d;
      drop_q      <= drop_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign sram_addr  = addr_q & {{(DATA_W-2){1'b1}}, 2'b00};
  assign sram_wdata = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign freez_if   = if_req & ~if_valid;
  assign freez_mem  = (mem_rd | mem_wr) & ~mem_ready;

endmodule
